// File: rtl/game_pkg.sv
// game_pkg: shared game state/winner encodings, default round constants and the score judge
package game_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} game_state_t;
  typedef enum logic [1:0] {NONE = 2'd0, P1 = 2'd1, P2 = 2'd2, DRAW = 2'd3} winner_t;
  localparam int GAME_TIME_S_DEF = 60;
  localparam int WIN_POINTS_DEF = 10;
  function automatic winner_t judge(logic [4:0] a, logic [4:0] b);
    return a > b ? P1 : a < b ? P2 : DRAW;
  endfunction
endpackage

// File: rtl/game_score_ctl_sec_tick_gen.sv
// sec_tick_gen: free-running one-second prescaler that pulses tick on its terminal count
module sec_tick_gen #(
  parameter int CLK_FREQ_HZ = 65_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = CLK_FREQ_HZ > 1 ? $clog2(CLK_FREQ_HZ) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == W'(CLK_FREQ_HZ - 1);
  // next count: clear wins, wrap on terminal count, hold when disabled
  always_comb cnt_d = clr ? '0 : tick ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/game_score_ctl.sv
// game_score_ctl: round FSM with countdown timer, score-win detection and winner selection
module game_score_ctl
  import game_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 65_000_000,
  parameter int GAME_TIME_S = GAME_TIME_S_DEF,
  parameter int WIN_POINTS = WIN_POINTS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] points_p1,
  input  logic [4:0] points_p2,
  output logic       game_rst,
  output logic [1:0] game_state,
  output logic [1:0] winner,
  output logic [6:0] time_left
);
  game_state_t state_q, state_d;
  winner_t winner_q, winner_d;
  logic [6:0] time_left_q, time_left_d;
  logic game_rst_q, game_rst_d, guard_q;
  logic play, go, sec_tick, score_win, time_up, finish;
  assign play = state_q == PLAY;
  assign go = !play && start;
  sec_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (play),
    .clr (go),
    .tick(sec_tick)
  );
  // scores are stale while the generators are being reset, so they are masked for two cycles
  always_comb begin
    score_win = play && !game_rst_q && !guard_q &&
                (points_p1 >= 5'(WIN_POINTS) || points_p2 >= 5'(WIN_POINTS));
    time_up = play && sec_tick && time_left_q == 7'd1;
    finish = score_win || time_up;
    state_d = go ? PLAY : finish ? OVER : state_q;
    winner_d = go ? NONE : finish ? judge(points_p1, points_p2) : winner_q;
    time_left_d = go ? 7'(GAME_TIME_S) :
                  (play && sec_tick && time_left_q != '0) ? time_left_q - 7'd1 : time_left_q;
    game_rst_d = go;
  end
  // state and output registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      winner_q <= NONE;
      time_left_q <= 7'(GAME_TIME_S);
      game_rst_q <= 1'b0;
      guard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      winner_q <= winner_d;
      time_left_q <= time_left_d;
      game_rst_q <= game_rst_d;
      guard_q <= game_rst_q;
    end
  assign game_rst = game_rst_q;
  assign game_state = state_q;
  assign winner = winner_q;
  assign time_left = time_left_q;
endmodule

// File: tb/tb_game_score_ctl.sv
// tb_game_score_ctl: scoreboard bench comparing the controller against a round-level reference model
module tb_game_score_ctl;
  localparam int F = 10, T = 3, W = 4;
  logic clk = 1'b0, rst, start;
  logic [4:0] points_p1, points_p2;
  logic game_rst;
  logic [1:0] game_state, winner;
  logic [6:0] time_left;
  typedef struct {int st; int win; int tl; int pulse;} exp_t;
  exp_t q[$];
  int checks = 0, passed = 0, cycle = 0;
  int m_st = 0, m_win = 0, m_tl = T, m_age = 0, m_pulse = 0;
  game_score_ctl #(.CLK_FREQ_HZ(F), .GAME_TIME_S(T), .WIN_POINTS(W)) dut (
    .clk(clk), .rst(rst), .start(start), .points_p1(points_p1), .points_p2(points_p2),
    .game_rst(game_rst), .game_state(game_state), .winner(winner), .time_left(time_left)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, int got, int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s cyc=%0d got=%0d exp=%0d", n, cycle, got, want);
  endtask
  // reference: a round is measured by its age in clock cycles; time left is whole seconds remaining
  task automatic step(bit r, bit s, int p1, int p2);
    int tl_old;
    if (r) begin
      m_st = 0; m_win = 0; m_tl = T; m_age = 0; m_pulse = 0;
    end else if (m_st != 1 && s) begin
      m_st = 1; m_win = 0; m_tl = T; m_age = 0; m_pulse = 1;
    end else begin
      m_pulse = 0;
      if (m_st == 1) begin
        tl_old = m_tl;
        m_age++;
        m_tl = T - m_age / F > 0 ? T - m_age / F : 0;
        if ((m_age >= 3 && (p1 >= W || p2 >= W)) || (tl_old == 1 && m_tl == 0)) begin
          m_st = 2;
          m_win = p1 > p2 ? 1 : p1 < p2 ? 2 : 3;
        end
      end
    end
    q.push_back('{m_st, m_win, m_tl, m_pulse});
  endtask
  task automatic cyc(bit r, bit s, int p1, int p2);
    @(negedge clk);
    rst = r; start = s; points_p1 = 5'(p1); points_p2 = 5'(p2);
    @(posedge clk);
    step(r, s, p1, p2);
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    cycle++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", int'(game_state), e.st);
      chk("winner", int'(winner), e.win);
      chk("time_left", int'(time_left), e.tl);
      chk("game_rst", int'(game_rst), e.pulse);
    end
  end
  initial begin
    int p1, p2;
    rst = 1'b1; start = 1'b0; points_p1 = '0; points_p2 = '0;
    repeat (3) cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); repeat (34) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); repeat (3) cyc(0, 0, 0, 2);
    for (int p = 0; p <= 4; p++) cyc(0, 0, p, 2);
    repeat (3) cyc(0, 0, 4, 2);
    cyc(0, 1, 0, 0); repeat (33) cyc(0, 0, 1, 1);
    cyc(0, 1, 0, 0); repeat (33) cyc(0, 0, 1, 3);
    cyc(0, 1, 0, 0); repeat (4) cyc(0, 0, 5, 4);
    repeat (45) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0); repeat (5) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); repeat (12) cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0); repeat (3) cyc(0, 0, 0, 0);
    p1 = 0; p2 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) p1 = $urandom_range(0, 5);
      if ($urandom_range(0, 7) == 0) p2 = $urandom_range(0, 5);
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, p1, p2);
    end
    @(negedge clk); @(negedge clk); #1;
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
